// File: rtl/scc_pkg.sv
// Shared definitions for the SCC core pipeline stages.
package scc_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned RegW  = 3;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// SCC memory-access stage: ALU pass-through or single-word load/store with a bounded wait,
// producing one registered write-back beat per instruction.
module mem_stage
  import scc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DataW:0]     ALU_results,
  input  logic [1:0]         mem_op,
  input  logic [RegW-1:0]    dest_reg,
  input  logic               wb_en_in,
  input  logic [DataW-1:0]   pointer_reg_value,
  input  logic [15:0]        offset,
  input  logic [DataW-1:0]   store_data,
  input  logic               flush,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DataW-1:0]   dmem_addr,
  output logic [DataW-1:0]   dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DataW-1:0]   dmem_rdata,
  output logic               wb_valid,
  output logic [RegW-1:0]    wb_reg,
  output logic [DataW-1:0]   wb_data,
  output logic               wb_carry,
  output logic               mem_fault
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  mem_state_t            state_q, state_d;
  logic                  rdy_q, rdy_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [DataW-1:0]      addr_q, addr_d;
  logic [DataW-1:0]      wdata_q, wdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  load_q, load_d;
  logic                  wb_en_q, wb_en_d;
  logic                  flushed_q, flushed_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [RegW-1:0]       wb_reg_q, wb_reg_d;
  logic [DataW-1:0]      wb_data_q, wb_data_d;
  logic                  wb_carry_q, wb_carry_d;
  logic                  fault_q, fault_d;

  logic                  capture;
  logic                  is_mem;
  logic                  squashed;
  logic [DataW-1:0]      addr_sum;

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready = rdy_q && (state_q == IDLE || state_q == DONE) && !flush;
  assign capture  = in_valid && in_ready;
  assign is_mem   = (mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE);
  assign addr_sum = pointer_reg_value + {{16{offset[15]}}, offset};
  assign squashed = flushed_q || flush;

  always_comb begin
    state_d    = state_q;
    rdy_d      = 1'b1;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    load_d     = load_q;
    wb_en_d    = wb_en_q;
    flushed_d  = flushed_q;
    wb_valid_d = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    wb_carry_d = wb_carry_q;
    fault_d    = 1'b0;

    unique case (state_q)
      REQ: begin
        if (flush) flushed_d = 1'b1;
        // Ack takes priority over expiry in the same cycle.
        if (dmem_ack) begin
          state_d    = DONE;
          req_d      = 1'b0;
          wb_valid_d = load_q && wb_en_q && !squashed;
          if (load_q) wb_data_d = dmem_rdata;
        end else if (cnt_q == TimeoutLast) begin
          state_d = DONE;
          req_d   = 1'b0;
          fault_d = !squashed;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      IDLE, DONE: begin
        if (capture) begin
          wb_reg_d   = dest_reg;
          wb_carry_d = ALU_results[DataW];
          wb_en_d    = wb_en_in;
          load_d     = (mem_op == MEM_OP_LOAD);
          if (!is_mem) begin
            state_d    = DONE;
            wb_valid_d = wb_en_in;
            wb_data_d  = ALU_results[DataW-1:0];
          end else if (addr_sum[1:0] != 2'b00) begin
            state_d = DONE;
            fault_d = 1'b1;
          end else begin
            state_d   = REQ;
            req_d     = 1'b1;
            we_d      = (mem_op == MEM_OP_STORE);
            addr_d    = addr_sum;
            wdata_d   = store_data;
            cnt_d     = 8'd0;
            flushed_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      load_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      flushed_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      wb_carry_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      wb_en_q    <= wb_en_d;
      flushed_q  <= flushed_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      wb_carry_q <= wb_carry_d;
      fault_q    <= fault_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  // A flush in the DONE cycle squashes the beat presented that cycle.
  assign wb_valid   = wb_valid_q && !flush;
  assign mem_fault  = fault_q && !flush;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;
  assign wb_carry   = wb_carry_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level timing model predicts request windows and
// write-back beats per instruction; a negedge compare process checks the DUT every cycle.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] ALU_results;
  logic [1:0]  mem_op;
  logic [2:0]  dest_reg;
  logic        wb_en_in;
  logic [31:0] pointer_reg_value;
  logic [15:0] offset;
  logic [31:0] store_data;
  logic        flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_carry;
  logic        mem_fault;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .ALU_results       (ALU_results),
    .mem_op            (mem_op),
    .dest_reg          (dest_reg),
    .wb_en_in          (wb_en_in),
    .pointer_reg_value (pointer_reg_value),
    .offset            (offset),
    .store_data        (store_data),
    .flush             (flush),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_ack          (dmem_ack),
    .dmem_rdata        (dmem_rdata),
    .wb_valid          (wb_valid),
    .wb_reg            (wb_reg),
    .wb_data           (wb_data),
    .wb_carry          (wb_carry),
    .mem_fault         (mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          valid;
    bit          fault;
    logic [2:0]  rg;
    logic [31:0] data;
    bit          carry;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          req_lo = -1;
  int          req_hi = -2;
  logic        exp_we;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  bit          en = 1'b0;
  bit          rdy_seen;
  bit          pin_en = 1'b0;
  logic [31:0] pin_addr;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_seen <= 1'b0;
    else        rdy_seen <= 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en) begin
      automatic bit  inreq = (cyc >= req_lo) && (cyc <= req_hi);
      automatic ev_t ev;
      check("in_ready", {31'b0, in_ready}, {31'b0, rdy_seen && !flush && !inreq});
      check("dmem_req", {31'b0, dmem_req}, {31'b0, inreq});
      if (inreq) begin
        check("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        ev = exp_q.pop_front();
        check("wb_valid", {31'b0, wb_valid}, {31'b0, ev.valid});
        check("mem_fault", {31'b0, mem_fault}, {31'b0, ev.fault});
        if (ev.valid) begin
          check("wb_reg", {29'b0, wb_reg}, {29'b0, ev.rg});
          check("wb_data", wb_data, ev.data);
          check("wb_carry", {31'b0, wb_carry}, {31'b0, ev.carry});
        end
      end else begin
        check("wb_valid_idle", {31'b0, wb_valid}, 32'd0);
        check("mem_fault_idle", {31'b0, mem_fault}, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // ack_k: REQ cycle carrying ack (0 = never); flush_j: REQ cycle carrying flush (0 = none).
  task automatic issue(input logic [1:0] op, input logic [32:0] alu, input logic [2:0] dst,
                       input logic wben, input logic [31:0] ptr, input logic [15:0] off,
                       input logic [31:0] sd, input int ack_k, input logic [31:0] rd,
                       input int flush_j, input bit flush_done);
    logic [31:0] a;
    int          e;
    int          len;
    bit          mem;
    bit          acked;
    bit          fl;
    ev_t         ev;
    a   = ptr + 32'($signed(off));
    mem = (op == 2'b01) || (op == 2'b10);
    ALU_results = alu; mem_op = op; dest_reg = dst; wb_en_in = wben;
    pointer_reg_value = ptr; offset = off; store_data = sd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = cyc;
    len = 0;
    ev.cyc = e; ev.rg = dst; ev.carry = alu[32]; ev.data = alu[31:0];
    ev.valid = 1'b0; ev.fault = 1'b0;
    if (!mem) begin
      ev.valid = wben;
    end else if (a[1:0] != 2'b00) begin
      ev.fault = 1'b1;
    end else begin
      acked = (ack_k >= 1) && (ack_k <= TO);
      len = acked ? ack_k : TO;
      fl = (flush_j >= 1) && (flush_j <= len);
      req_lo = e; req_hi = e + len - 1;
      exp_we = (op == 2'b10); exp_addr = a; exp_wdata = sd;
      ev.cyc = e + len;
      if (acked) begin
        ev.valid = (op == 2'b01) && wben && !fl;
        ev.data = rd;
      end else begin
        ev.fault = !fl;
      end
    end
    if (flush_done) begin
      ev.valid = 1'b0;
      ev.fault = 1'b0;
    end
    exp_q.push_back(ev);
    for (int j = 1; j <= len; j++) begin
      if (j == 1 && pin_en) check("pin_dmem_addr", dmem_addr, pin_addr);
      dmem_ack   = (j == ack_k);
      dmem_rdata = (j == ack_k) ? rd : 32'h0BAD_0BAD;
      flush      = (j == flush_j);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      flush    = 1'b0;
    end
    if (flush_done) begin
      flush = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; ALU_results = 33'h1_FFFF_FFFF; mem_op = 2'b01;
    dest_reg = 3'd7; wb_en_in = 1'b1; pointer_reg_value = 32'h100; offset = 16'h0;
    store_data = 32'h0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through with carry, pinned by literals
    issue(2'b00, 33'h1_0000_0005, 3'd3, 1'b1, 32'h0, 16'h0, 32'h0, 0, 32'h0, 0, 1'b0);
    check("lit_alu_valid", {31'b0, wb_valid}, 32'd1);
    check("lit_alu_reg", {29'b0, wb_reg}, 32'd3);
    check("lit_alu_data", wb_data, 32'd5);
    check("lit_alu_carry", {31'b0, wb_carry}, 32'd1);
    // Back-to-back: op 11 acts as none; wb_en_in=0 gives no beat
    issue(2'b11, 33'h0_1234_5678, 3'd6, 1'b1, 32'h3, 16'h0, 32'h0, 0, 32'h0, 0, 1'b0);
    issue(2'b00, 33'h1_FFFF_FFFF, 3'd2, 1'b0, 32'h0, 16'h0, 32'h0, 0, 32'h0, 0, 1'b0);
    idle(2);

    // Load with negative offset, ack in third REQ cycle
    pin_en = 1'b1; pin_addr = 32'h0000_00FC;
    issue(2'b01, 33'h0, 3'd5, 1'b1, 32'h100, 16'hFFFC, 32'h0, 3, 32'hDEAD_BEEF, 0, 1'b0);
    pin_en = 1'b0;
    check("lit_load_data", wb_data, 32'hDEAD_BEEF);
    check("lit_load_valid", {31'b0, wb_valid}, 32'd1);

    // Store, ack first cycle: no beat even with wb_en_in
    issue(2'b10, 33'h0_0000_00AA, 3'd4, 1'b1, 32'h200, 16'h0008, 32'h1234_5678, 1, 32'h0, 0,
          1'b0);
    // Misaligned load: fault next cycle, no request
    issue(2'b01, 33'h0, 3'd1, 1'b1, 32'h100, 16'h0002, 32'h0, 1, 32'h0, 0, 1'b0);
    check("lit_misalign_fault", {31'b0, mem_fault}, 32'd1);
    check("lit_misalign_req", {31'b0, dmem_req}, 32'd0);
    // Timeout: request held TO cycles then fault
    issue(2'b01, 33'h0, 3'd7, 1'b1, 32'h300, 16'h0, 32'h0, 0, 32'h0, 0, 1'b0);
    check("lit_timeout_fault", {31'b0, mem_fault}, 32'd1);
    // Flush in REQ, ack two cycles later: silent completion
    issue(2'b01, 33'h0, 3'd1, 1'b1, 32'h400, 16'h0004, 32'h0, 3, 32'hCAFE_F00D, 1, 1'b0);
    idle(1);
    // Ack coincident with expiry: ack wins
    issue(2'b01, 33'h0, 3'd2, 1'b1, 32'h500, 16'hFFFC, 32'h0, TO, 32'h0BAD_CAFE, 0, 1'b0);
    // Flush in DONE squashes the beat and blocks capture
    issue(2'b00, 33'h0_0000_0077, 3'd1, 1'b1, 32'h0, 16'h0, 32'h0, 0, 32'h0, 0, 1'b1);
    // Flush in IDLE with in_valid: nothing captured
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    // Misaligned store, then wrap-around address load, then load with wb_en_in=0
    issue(2'b10, 33'h0, 3'd3, 1'b1, 32'h11, 16'h0, 32'hFFFF_0000, 1, 32'h0, 0, 1'b0);
    issue(2'b01, 33'h1_0000_0000, 3'd6, 1'b1, 32'hFFFF_FFF0, 16'h0020, 32'h0, 2,
          32'h1357_9BDF, 0, 1'b0);
    issue(2'b01, 33'h0, 3'd6, 1'b0, 32'h80, 16'h0, 32'h0, 1, 32'h2468_ACE0, 0, 1'b0);
    idle(2);
    check("events_drained", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a request
    en = 1'b0;
    ALU_results = 33'h0; mem_op = 2'b01; dest_reg = 3'd2; wb_en_in = 1'b1;
    pointer_reg_value = 32'h40; offset = 16'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_req_up", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    check("abort_req_held", {31'b0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_req", {31'b0, dmem_req}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd0);
    check("abort_addr", dmem_addr, 32'd0);
    check("abort_we", {31'b0, dmem_we}, 32'd0);
    check("abort_fault", {31'b0, mem_fault}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 50000");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the SCC core, directly downstream of the execute stage. It accepts one EX-stage result per handshake and either forwards the ALU result or performs a single-word load/store on the data-memory port, with a bounded wait. It presents one write-back beat per instruction to the register file.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum cycles `dmem_req` is held without `dmem_ack` before a fault; legal range 1–255.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  EX result present.
- `in_ready`  out  1  stage can accept this cycle.
- `ALU_results`  in  33  EX result; [31:0] data, [32] carry-out.
- `mem_op`  in  2  00 none, 01 load, 10 store, 11 treated as none.
- `dest_reg`  in  3  write-back register index.
- `wb_en_in`  in  1  instruction writes a register.
- `pointer_reg_value`  in  32  base address.
- `offset`  in  16  signed address offset.
- `store_data`  in  32  store word.
- `flush`  in  1  squash in-flight instruction.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word address.
- `dmem_wdata`  out  32  store data.
- `dmem_ack`  in  1  request complete; `dmem_rdata` valid this cycle.
- `dmem_rdata`  in  32  load data.
- `wb_valid`  out  1  write-back beat.
- `wb_reg`  out  3  destination index.
- `wb_data`  out  32  write-back value.
- `wb_carry`  out  1  captured `ALU_results[32]`.
- `mem_fault`  out  1  misalign/timeout pulse.

## Operation
- States: IDLE, REQ, DONE. Reset → IDLE. Every output is 0 at reset, including `in_ready`. `in_ready` rises the first cycle after reset release.
- `in_ready = (state==IDLE || state==DONE) && !flush`. Capture occurs on `in_valid && in_ready`.
- On capture, `addr = pointer_reg_value + sext(offset)`, computed in 32 bits with wrap-around modulo 2^32. All inputs are registered.
- mem_op none/11: → DONE. `wb_data = ALU_results[31:0]`, `wb_valid = wb_en_in`.
- Load/store with `addr[1:0]!=0`: no request is issued. → DONE with `wb_valid=0` and `mem_fault=1`.
- Aligned load/store: → REQ.
  - `dmem_req=1`, with `dmem_we`, `dmem_addr` and `dmem_wdata` held stable until leaving REQ.
  - The wait counter is cleared on entry and increments each REQ cycle.
- REQ with `dmem_ack`: → DONE.
  - Load: `wb_data = dmem_rdata`, `wb_valid = wb_en_in`.
  - Store: `wb_valid=0`.
- REQ, no ack, counter == `TIMEOUT-1`: drop `dmem_req`, → DONE with `mem_fault=1` and `wb_valid=0`. If ack and expiry occur in the same cycle, ack wins.
- DONE lasts one cycle.
  - A new capture in DONE goes straight to the next state, giving back-to-back throughput.
  - Otherwise → IDLE.
- `flush`:
  - In IDLE/DONE: `wb_valid` and `mem_fault` are forced to 0 that cycle, and nothing is captured.
  - In REQ: the request is never withdrawn early. The stage waits for ack or timeout, and the resulting DONE has `wb_valid=0` and `mem_fault=0`.
- Asynchronous reset mid-REQ drops `dmem_req` immediately. The memory side must tolerate the abort.

## Timing
- ALU pass-through: capture edge N → `wb_valid` in cycle N+1.
- Memory op with ack in the k-th REQ cycle (k≥1): `wb_valid` in cycle N+k+1.
- Timeout: `mem_fault` in cycle N+TIMEOUT+1.
- Misalignment: `mem_fault` in cycle N+1.
- `wb_*` and `mem_fault` are registered outputs, valid only in DONE. `in_ready` is combinational from state and `flush`.
- Throughput: one instruction per cycle when no memory op is pending.

## Structure
- `scc_pkg` holds:
  - `MEM_OP_NONE=2'b00`, `MEM_OP_LOAD=2'b01`, `MEM_OP_STORE=2'b10`.
  - The `mem_state_t` enum (IDLE/REQ/DONE).
  - Shared widths: data 32, register index 3.
- Single module, no sub-module. The address adder and timeout counter (8 bits) are inline.

## Test plan
- ALU pass-through: ALU_results=33'h1_0000_0005, wb_en_in=1, dest_reg=3 → next cycle wb_valid=1, wb_reg=3, wb_data=5, wb_carry=1.
- Load: pointer=32'h100, offset=16'hFFFC → dmem_addr=32'hFC. Ack after 3 cycles with rdata=32'hDEAD_BEEF → wb_data=32'hDEADBEEF, wb_valid one cycle later.
- Store with wb_en_in=1, ack in the first REQ cycle → dmem_we=1 and dmem_wdata=store_data; wb_valid stays 0.
- Misaligned load (addr=32'h102) → dmem_req never asserted; mem_fault=1 at N+1. Timeout: no ack with TIMEOUT=4 → req high exactly 4 cycles, then mem_fault.
- Flush during REQ, ack 2 cycles later → no wb_valid, no fault, in_ready returns. Ack coincident with the timeout cycle → normal completion. Reset asserted mid-REQ → all outputs 0 asynchronously.
